// File: rtl/enemy_pkg.sv
// Shared constants and types for the enemy plane logic and drawing path.
//   N_PLANES / COORD_W / SPRITE : plane count, coordinate width, sprite edge
//   hit_state_t                 : hit detector FSM states
//   BLACK / WHITE               : colour constants used by the drawing path
//   in_span()                   : one-axis hit-box test, widened so ex+SPRITE-1
//                                 never wraps
package enemy_pkg;

  localparam int unsigned N_PLANES = 10;
  localparam int unsigned COORD_W  = 8;
  localparam int unsigned SPRITE   = 5;
  localparam int unsigned IDX_W    = 4;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_PLANES - 1);
  localparam logic [15:0]      SCORE_MAX = 16'h9999;

  localparam logic [11:0] BLACK = 12'h000;
  localparam logic [11:0] WHITE = 12'hFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } hit_state_t;

  // True when p lies within [lo, lo+SPRITE-1], evaluated on COORD_W+1 bits.
  function automatic logic in_span(input logic [COORD_W-1:0] lo,
                                   input logic [COORD_W-1:0] p);
    logic [COORD_W:0] lo_e;
    logic [COORD_W:0] p_e;
    lo_e = {1'b0, lo};
    p_e  = {1'b0, p};
    return (p_e >= lo_e) && (p_e <= lo_e + (COORD_W+1)'(SPRITE - 1));
  endfunction

endpackage

// File: rtl/enemy_hit_detector_bcd_score_counter.sv
// bcd_score_counter: 4-digit BCD hit counter, saturating at 9999.
//   clk, reset_n : clock, synchronous active-low reset
//   inc          : add one this cycle (ignored once at SCORE_MAX)
//   count        : BCD value, digit 0 in bits [3:0]
module bcd_score_counter
  import enemy_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] next_count;
  logic        carry;

  // Ripple the +1 through the digits; a digit at 9 wraps to 0 and passes carry.
  always_comb begin
    next_count = count;
    carry      = 1'b1;
    for (int unsigned d = 0; d < 4; d++) begin
      if (carry) begin
        if (count[d*4 +: 4] == 4'd9) begin
          next_count[d*4 +: 4] = 4'd0;
        end else begin
          next_count[d*4 +: 4] = count[d*4 +: 4] + 4'd1;
          carry                = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != SCORE_MAX)) begin
      count <= next_count;
    end
  end

endmodule

// File: rtl/enemy_hit_detector.sv
// enemy_hit_detector: tests a player bullet against every enemy plane, one
// plane per cycle, and pulses `destroyed` for the lowest-indexed plane hit.
//   clk, reset_n           : clock, synchronous active-low reset
//   check_req              : start a test (accepted only when idle)
//   bullet_x, bullet_y     : bullet position, captured on acceptance
//   enemy_x, enemy_y       : packed plane positions, plane k at [k*COORD_W +: COORD_W]
//   enemy_active           : per-plane enable
//   busy                   : scan or report in progress
//   done, hit, hit_idx     : one-cycle result
//   destroyed              : one-hot pulse to the hit plane
//   score                  : BCD hit count
// Optional macro ENEMY_SCORE_EN enables the score counter; otherwise score is 0.
module enemy_hit_detector
  import enemy_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         check_req,
  input  logic [COORD_W-1:0]           bullet_x,
  input  logic [COORD_W-1:0]           bullet_y,
  input  logic [N_PLANES*COORD_W-1:0]  enemy_x,
  input  logic [N_PLANES*COORD_W-1:0]  enemy_y,
  input  logic [N_PLANES-1:0]          enemy_active,
  output logic                         busy,
  output logic                         done,
  output logic                         hit,
  output logic [IDX_W-1:0]             hit_idx,
  output logic [N_PLANES-1:0]          destroyed,
  output logic [15:0]                  score
);

  hit_state_t                  state;
  logic [IDX_W-1:0]            k;
  logic [COORD_W-1:0]          snap_bx;
  logic [COORD_W-1:0]          snap_by;
  logic [N_PLANES*COORD_W-1:0] snap_x;
  logic [N_PLANES*COORD_W-1:0] snap_y;
  logic [N_PLANES-1:0]         snap_active;

  logic [COORD_W-1:0]          cur_x;
  logic [COORD_W-1:0]          cur_y;
  logic                        plane_match;

  always_comb begin
    cur_x       = snap_x[k*COORD_W +: COORD_W];
    cur_y       = snap_y[k*COORD_W +: COORD_W];
    plane_match = snap_active[k] && in_span(cur_x, snap_bx) && in_span(cur_y, snap_by);
  end

  // Result outputs are loaded on the SCAN->REPORT edge so they are valid for
  // exactly the REPORT cycle, then cleared on the way back to IDLE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      k           <= '0;
      snap_bx     <= '0;
      snap_by     <= '0;
      snap_x      <= '0;
      snap_y      <= '0;
      snap_active <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hit         <= 1'b0;
      hit_idx     <= '0;
      destroyed   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done      <= 1'b0;
          hit       <= 1'b0;
          destroyed <= '0;
          if (check_req) begin
            snap_bx     <= bullet_x;
            snap_by     <= bullet_y;
            snap_x      <= enemy_x;
            snap_y      <= enemy_y;
            snap_active <= enemy_active;
            k           <= '0;
            busy        <= 1'b1;
            state       <= SCAN;
          end
        end
        SCAN: begin
          if (plane_match) begin
            hit_idx   <= k;
            hit       <= 1'b1;
            done      <= 1'b1;
            destroyed <= {{(N_PLANES-1){1'b0}}, 1'b1} << k;
            state     <= REPORT;
          end else if (k == LAST_IDX) begin
            hit       <= 1'b0;
            done      <= 1'b1;
            destroyed <= '0;
            state     <= REPORT;
          end else begin
            k <= k + 1'b1;
          end
        end
        REPORT: begin
          done      <= 1'b0;
          hit       <= 1'b0;
          destroyed <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ENEMY_SCORE_EN
  bcd_score_counter u_score (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (done && hit),
    .count   (score)
  );
`else
  assign score = '0;
`endif

endmodule

// File: tb/tb_enemy_hit_detector.sv
// Self-checking bench for enemy_hit_detector. Requests push the expected
// outcome (from a behavioural scan model) into a scoreboard; a negedge
// monitor pops and compares whenever done is seen.
module tb_enemy_hit_detector;
  import enemy_pkg::*;

  logic                        clk = 1'b0;
  logic                        reset_n = 1'b0;
  logic                        check_req = 1'b0;
  logic [COORD_W-1:0]          bullet_x = '0;
  logic [COORD_W-1:0]          bullet_y = '0;
  logic [N_PLANES*COORD_W-1:0] enemy_x = '0;
  logic [N_PLANES*COORD_W-1:0] enemy_y = '0;
  logic [N_PLANES-1:0]         enemy_active = '0;
  logic                        busy;
  logic                        done;
  logic                        hit;
  logic [IDX_W-1:0]            hit_idx;
  logic [N_PLANES-1:0]         destroyed;
  logic [15:0]                 score;

  enemy_hit_detector dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .check_req    (check_req),
    .bullet_x     (bullet_x),
    .bullet_y     (bullet_y),
    .enemy_x      (enemy_x),
    .enemy_y      (enemy_y),
    .enemy_active (enemy_active),
    .busy         (busy),
    .done         (done),
    .hit          (hit),
    .hit_idx      (hit_idx),
    .destroyed    (destroyed),
    .score        (score)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic                hit;
    logic [IDX_W-1:0]    idx;
    logic [N_PLANES-1:0] dmask;
    int                  due;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_hits = 0;
  int   px[N_PLANES];
  int   py[N_PLANES];

  function automatic logic [15:0] exp_score();
`ifdef ENEMY_SCORE_EN
    int v;
    v = (exp_hits > 9999) ? 9999 : exp_hits;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
`else
    return 16'h0000;
`endif
  endfunction

  function automatic int ref_scan(int bx, int by, logic [N_PLANES-1:0] act);
    for (int i = 0; i < N_PLANES; i++) begin
      if (act[i] && px[i] <= bx && bx <= px[i] + 4 && py[i] <= by && by <= py[i] + 4)
        return i;
    end
    return -1;
  endfunction

  // Monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (reset_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_done cyc=%0d hit=%0b idx=%0d required=no done", cyc, hit, hit_idx);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checks++;
          if (cyc !== e.due) begin
            errors++;
            $display("FAIL done_cycle got=%0d required=%0d", cyc, e.due);
          end
          checks++;
          if (hit !== e.hit) begin
            errors++;
            $display("FAIL hit got=%0b required=%0b", hit, e.hit);
          end
          checks++;
          if (destroyed !== e.dmask) begin
            errors++;
            $display("FAIL destroyed got=%h required=%h", destroyed, e.dmask);
          end
          checks++;
          if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_report got=%0b required=1", busy);
          end
          if (e.hit) begin
            checks++;
            if (hit_idx !== e.idx) begin
              errors++;
              $display("FAIL hit_idx got=%0d required=%0d", hit_idx, e.idx);
            end
            exp_hits++;
          end
        end
      end else begin
        checks++;
        if (destroyed !== '0 || hit !== 1'b0) begin
          errors++;
          $display("FAIL idle_pulse cyc=%0d destroyed=%h hit=%0b required=0", cyc, destroyed, hit);
        end
      end
    end
  end

  task automatic park_all();
    for (int i = 0; i < N_PLANES; i++) begin
      px[i] = 220;
      py[i] = 220;
    end
  endtask

  task automatic apply_planes();
    for (int i = 0; i < N_PLANES; i++) begin
      enemy_x[i*COORD_W +: COORD_W] = COORD_W'(px[i]);
      enemy_y[i*COORD_W +: COORD_W] = COORD_W'(py[i]);
    end
  endtask

  // Drive one request; returns just after the sampling edge.
  task automatic fire(input int bx, input int by);
    exp_t e;
    int   r;
    bullet_x = COORD_W'(bx);
    bullet_y = COORD_W'(by);
    apply_planes();
    r = ref_scan(bx, by, enemy_active);
    @(negedge clk);
    check_req = 1'b1;
    @(posedge clk);
    #1;
    check_req = 1'b0;
    e.hit   = (r >= 0);
    e.idx   = (r >= 0) ? IDX_W'(r) : '0;
    e.dmask = (r >= 0) ? (N_PLANES'(1) << r) : '0;
    e.due   = cyc + ((r >= 0) ? (2 + r) : 11) - 1;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      errors++; checks++;
      $display("FAIL drain_timeout pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_score(input string tag);
    @(negedge clk);
    checks++;
    if (score !== exp_score()) begin
      errors++;
      $display("FAIL score_%s got=%h required=%h", tag, score, exp_score());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_req = 1'b1;          // request during reset must be ignored
    @(negedge clk);
    check_req = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, hit, hit_idx, destroyed, score} !== '0) begin
      errors++;
      $display("FAIL reset_outputs busy=%0b done=%0b hit=%0b idx=%0d destroyed=%h score=%h required=all 0",
               busy, done, hit, hit_idx, destroyed, score);
    end
  endtask

  task automatic test_direct_hit();
    park_all();
    enemy_active = 10'h3FF;
    px[3] = 40; py[3] = 20;
    apply_planes();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_before_req got=%0b required=0", busy);
    end
    fire(42, 22);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_req got=%0b required=1", busy);
    end
    wait_drain();
    check_score("direct");
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_report got=%0b required=0", busy);
    end
  endtask

  task automatic test_priority();
    park_all();
    enemy_active = 10'h3FF;
    px[2] = 60; py[2] = 60;
    px[7] = 60; py[7] = 60;
    fire(60, 64);
    wait_drain();
    check_score("priority");
  endtask

  task automatic test_edges();
    park_all();
    enemy_active = 10'h3FE;
    px[0] = 30; py[0] = 30;
    fire(31, 31);              // inactive plane covers bullet -> miss
    wait_drain();
    enemy_active = 10'h3FF;
    px[0] = 100; py[0] = 100;
    fire(105, 102);            // bx = ex+5 -> miss
    wait_drain();
    fire(104, 104);            // far corner -> hit
    wait_drain();
    fire(100, 99);             // by = ey-1 -> miss
    wait_drain();
    px[0] = 253; py[0] = 50;
    fire(1, 52);               // no wrap-around -> miss
    wait_drain();
    fire(255, 54);             // top of widened span -> hit
    wait_drain();
    px[0] = 50; py[0] = 253;
    fire(52, 1);
    wait_drain();
    check_score("edges");
  endtask

  task automatic test_busy_ignore();
    park_all();
    enemy_active = 10'h3FF;
    px[5] = 80; py[5] = 80;
    fire(81, 81);
    repeat (3) @(negedge clk);
    // Retarget everything while scanning; none of it may matter.
    px[5] = 10; py[5] = 10;
    px[0] = 0;  py[0] = 0;
    apply_planes();
    bullet_x = '0;
    bullet_y = '0;
    check_req = 1'b1;
    @(posedge clk);
    #1;
    check_req = 1'b0;
    wait_drain();
    repeat (14) @(negedge clk);
    check_score("busy");
  endtask

  task automatic test_reset_midscan();
    park_all();
    enemy_active = '0;
    fire(10, 10);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    check_req = 1'b1;
    sb.delete();
    @(negedge clk);
    #1;
    checks++;
    if ({busy, done, hit, hit_idx, destroyed, score} !== '0) begin
      errors++;
      $display("FAIL midscan_reset busy=%0b done=%0b hit=%0b idx=%0d destroyed=%h score=%h required=all 0",
               busy, done, hit, hit_idx, destroyed, score);
    end
    exp_hits = 0;
    check_req = 1'b0;
    reset_n = 1'b1;
    enemy_active = 10'h3FF;
    px[4] = 120; py[4] = 90;
    fire(122, 91);
    wait_drain();
    check_score("after_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < N_PLANES; i++) begin
        px[i] = $urandom_range(0, 60);
        py[i] = $urandom_range(0, 60);
      end
      enemy_active = N_PLANES'($urandom);
      fire($urandom_range(0, 64), $urandom_range(0, 64));
      wait_drain();
    end
    check_score("random");
  endtask

  task automatic test_score_saturation();
`ifdef ENEMY_SCORE_EN
    park_all();
    enemy_active = 10'h3FF;
    px[0] = 5; py[0] = 5;
    while (exp_hits < 9999) begin
      fire(6, 6);
      wait_drain();
    end
    check_score("at_9999");
    fire(6, 6);
    wait_drain();
    check_score("saturated");
`endif
  endtask

  initial begin
    test_reset();
    test_direct_hit();
    test_priority();
    test_edges();
    test_busy_ignore();
    test_reset_midscan();
    test_random();
    test_score_saturation();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
